// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between r0 (EX stage, owns Z/N/V flags) and r1 (aux engine).
// Define ALU_ARB_LOCK_EN to add the r0 priority lock with the r1 starvation guard.
module alu_share_arb #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_r0_valid,
  output logic              o_r0_ready,
  input  logic [2:0]        i_r0_op,
  input  logic [DATA_W-1:0] i_r0_a,
  input  logic [DATA_W-1:0] i_r0_b,
  input  logic              i_r1_valid,
  output logic              o_r1_ready,
  input  logic [2:0]        i_r1_op,
  input  logic [DATA_W-1:0] i_r1_a,
  input  logic [DATA_W-1:0] i_r1_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic              i_r0_lock,
`endif
  output logic [DATA_W-1:0] o_alu_in1,
  output logic [DATA_W-1:0] o_alu_in2,
  output logic [2:0]        o_alu_opcode,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [2:0]        i_alu_flags,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [2:0]        o_flags
);

  localparam bit ParamsOk = (DATA_W == 16) && (STARVE_MAX >= 1) && (STARVE_MAX <= 7);

  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic [2:0]        r_flags;
  logic              r_last_grant;

  logic              w_r0_pref;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_gnt;
  logic [2:0]        w_flag_mask;

`ifdef ALU_ARB_LOCK_EN
  logic [2:0]        r_starve_cnt;
  logic              w_starve_hit;
`endif

  // w_r0_pref decides only genuine conflicts; a lone valid is always granted.
  always_comb begin
    w_r0_pref = r_last_grant;
`ifdef ALU_ARB_LOCK_EN
    w_starve_hit = (r_starve_cnt == 3'(STARVE_MAX));
    if (w_starve_hit) begin
      w_r0_pref = 1'b0;
    end else if (i_r0_lock) begin
      w_r0_pref = 1'b1;
    end
`endif
  end

  // Grants are suppressed while reset is asserted so no ready leaks out.
  assign w_gnt0 = i_rst_n & i_r0_valid & (~i_r1_valid | w_r0_pref);
  assign w_gnt1 = i_rst_n & i_r1_valid & (~i_r0_valid | ~w_r0_pref);
  assign w_gnt  = w_gnt0 | w_gnt1;

  assign o_r0_ready = w_gnt0;
  assign o_r1_ready = w_gnt1;

  always_comb begin
    o_alu_in1    = '0;
    o_alu_in2    = '0;
    o_alu_opcode = 3'b000;
    if (w_gnt0) begin
      o_alu_in1    = i_r0_a;
      o_alu_in2    = i_r0_b;
      o_alu_opcode = i_r0_op;
    end else if (w_gnt1) begin
      o_alu_in1    = i_r1_a;
      o_alu_in2    = i_r1_b;
      o_alu_opcode = i_r1_op;
    end
  end

  // Bit order {V,N,Z}: arithmetic ops own all three, logic/shift ops only Z.
  always_comb begin
    w_flag_mask = 3'b000;
    unique case (i_r0_op)
      3'b000, 3'b001:                 w_flag_mask = 3'b111;
      3'b010, 3'b100, 3'b101, 3'b110: w_flag_mask = 3'b001;
      default:                        w_flag_mask = 3'b000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_flags      <= 3'b000;
      r_last_grant <= 1'b1;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_gnt) begin
        r_rsp_id     <= w_gnt1;
        r_rsp_data   <= i_alu_out;
        r_last_grant <= w_gnt1;
      end
      if (w_gnt0) begin
        r_flags <= (r_flags & ~w_flag_mask) | (i_alu_flags & w_flag_mask);
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= 3'd0;
    end else if (!i_r1_valid || w_gnt1) begin
      r_starve_cnt <= 3'd0;
    end else if (r_starve_cnt != 3'd7) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end
`endif

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_flags     = r_flags;

  a_params_ok: assert property (@(posedge i_clk) ParamsOk);

  a_one_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_r0_ready && o_r1_ready));

  a_ready_has_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (!o_r0_ready || i_r0_valid) && (!o_r1_ready || i_r1_valid));

  a_rsp_follows_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_r0_ready || o_r1_ready) |=> o_rsp_valid);

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized and directed bench for alu_share_arb against a spec-level reference model.
// Also exercises the r0 lock path when built with ALU_ARB_LOCK_EN.
module tb_alu_share_arb;

  localparam int unsigned StarveMax = 4;

  logic        clk;
  logic        rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [2:0]  r0_op, r1_op;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
`ifdef ALU_ARB_LOCK_EN
  logic        r0_lock;
`endif
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_opcode, alu_flags;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic [2:0]  flags;

  int n_checks;
  int n_errors;

  // Reference model state.
  int          m_last;
  int unsigned m_starve;
  logic [2:0]  m_flags;
  logic        m_rsp_valid, m_rsp_id;
  logic [15:0] m_rsp_data;

  // DUT observations from the most recent cycle.
  logic        seen_rdy0, seen_rdy1;
  logic [2:0]  seen_aflags, seen_op;
  logic [15:0] seen_in1, seen_in2;

  alu_share_arb #(.DATA_W(16), .STARVE_MAX(StarveMax)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_r0_valid   (r0_valid),
    .o_r0_ready   (r0_ready),
    .i_r0_op      (r0_op),
    .i_r0_a       (r0_a),
    .i_r0_b       (r0_b),
    .i_r1_valid   (r1_valid),
    .o_r1_ready   (r1_ready),
    .i_r1_op      (r1_op),
    .i_r1_a       (r1_a),
    .i_r1_b       (r1_b),
`ifdef ALU_ARB_LOCK_EN
    .i_r0_lock    (r0_lock),
`endif
    .o_alu_in1    (alu_in1),
    .o_alu_in2    (alu_in2),
    .o_alu_opcode (alu_opcode),
    .i_alu_out    (alu_out),
    .i_alu_flags  (alu_flags),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .o_flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {V,N,Z,result}.
  function automatic logic [18:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    int          s;
    int          na;
    logic [31:0] rr;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0) s = int'($signed(a)) + int'($signed(b));
        else            s = int'($signed(a)) - int'($signed(b));
        if (s > 32767) begin
          r = 16'h7FFF;
          v = 1'b1;
        end else if (s < -32768) begin
          r = 16'h8000;
          v = 1'b1;
        end else begin
          r = s[15:0];
        end
      end
      3'd2: r = a ^ b;
      3'd3: r = 16'(a[15:8]) + 16'(a[7:0]) + 16'(b[15:8]) + 16'(b[7:0]);
      3'd4: r = a << b[3:0];
      3'd5: r = $signed(a) >>> b[3:0];
      3'd6: begin
        rr = {a, a} >> b[3:0];
        r  = rr[15:0];
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          na = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
          if (na > 7) na = 7;
          else if (na < -8) na = -8;
          r[4*i +: 4] = na[3:0];
        end
      end
    endcase
    return {v, r[15], (r == 16'h0000), r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_fn(alu_opcode, alu_in1, alu_in2);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last      = 1;
    m_starve    = 0;
    m_flags     = 3'b000;
    m_rsp_valid = 1'b0;
    m_rsp_id    = 1'b0;
    m_rsp_data  = 16'h0000;
  endtask

  // Returns -1 for no grant, else the granted requester id.
  function automatic int model_grant();
    bit lock;
    lock = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    lock = r0_lock;
`endif
    if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_LOCK_EN
      if (m_starve == StarveMax) return 1;
`endif
      if (lock) return 0;
      return (m_last == 1) ? 0 : 1;
    end
    if (r0_valid) return 0;
    if (r1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_r0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    r0_valid = 1'b1;
    r0_op    = op;
    r0_a     = a;
    r0_b     = b;
  endtask

  task automatic set_r1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    r1_valid = 1'b1;
    r1_op    = op;
    r1_a     = a;
    r1_b     = b;
  endtask

  task automatic rand_r0();
    logic [15:0] a;
    a = pick_operand();
    set_r0(3'($urandom), a, ($urandom_range(0, 4) == 0) ? a : pick_operand());
  endtask

  task automatic rand_r1();
    set_r1(3'($urandom), pick_operand(), pick_operand());
  endtask

  // One clock: check outputs at negedge, advance the model, retire the granted request.
  task automatic cycle();
    int          g;
    logic [18:0] res;
    logic [15:0] e_in1, e_in2;
    logic [2:0]  e_op;
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    check_eq("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    check_eq("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
    check_eq("flags", 32'(flags), 32'(m_flags));
    g = model_grant();
    seen_rdy0   = r0_ready;
    seen_rdy1   = r1_ready;
    seen_aflags = alu_flags;
    seen_in1    = alu_in1;
    seen_in2    = alu_in2;
    seen_op     = alu_opcode;
    check_eq("r0_ready", 32'(r0_ready), 32'(g == 0));
    check_eq("r1_ready", 32'(r1_ready), 32'(g == 1));
    e_in1 = 16'h0;
    e_in2 = 16'h0;
    e_op  = 3'd0;
    if (g == 0) begin
      e_in1 = r0_a;
      e_in2 = r0_b;
      e_op  = r0_op;
    end else if (g == 1) begin
      e_in1 = r1_a;
      e_in2 = r1_b;
      e_op  = r1_op;
    end
    check_eq("alu_in1", 32'(alu_in1), 32'(e_in1));
    check_eq("alu_in2", 32'(alu_in2), 32'(e_in2));
    check_eq("alu_opcode", 32'(alu_opcode), 32'(e_op));
    m_rsp_valid = (g >= 0);
    if (g >= 0) begin
      res        = alu_fn(e_op, e_in1, e_in2);
      m_rsp_id   = (g == 1);
      m_rsp_data = res[15:0];
      m_last     = g;
      if (g == 0) begin
        if (e_op == 3'd0 || e_op == 3'd1) m_flags = res[18:16];
        else if (e_op != 3'd3 && e_op != 3'd7) m_flags[0] = res[16];
      end
    end
`ifdef ALU_ARB_LOCK_EN
    if (!r1_valid || g == 1) m_starve = 0;
    else if (m_starve < 7) m_starve++;
`endif
    @(posedge clk);
    #1;
    if (g == 0) r0_valid = 1'b0;
    if (g == 1) r1_valid = 1'b0;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      if (!r0_valid && $urandom_range(0, 9) < 6) rand_r0();
      if (!r1_valid && $urandom_range(0, 9) < 6) rand_r1();
`ifdef ALU_ARB_LOCK_EN
      if ($urandom_range(0, 15) == 0) r0_lock = ~r0_lock;
`endif
      cycle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r0_op    = 3'd0;
    r1_op    = 3'd0;
    r0_a     = 16'h0;
    r0_b     = 16'h0;
    r1_a     = 16'h0;
    r1_b     = 16'h0;
`ifdef ALU_ARB_LOCK_EN
    r0_lock  = 1'b0;
`endif
    model_reset();
    #3;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_flags", 32'(flags), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Conflict: r0 first (reset last_grant), then r1.
    set_r0(3'd0, 16'h0003, 16'h0004);
    set_r1(3'd2, 16'h00FF, 16'h0F0F);
    cycle();
    check_eq("t2_rdy0", 32'(seen_rdy0), 32'd1);
    check_eq("t2_rsp0_data", 32'(rsp_data), 32'h0007);
    check_eq("t2_rsp0_id", 32'(rsp_id), 32'd0);
    cycle();
    check_eq("t2_rdy1", 32'(seen_rdy1), 32'd1);
    check_eq("t2_rsp1_data", 32'(rsp_data), 32'h0FF0);
    check_eq("t2_rsp1_id", 32'(rsp_id), 32'd1);

    // Zero flag, then saturating overflow.
    set_r0(3'd1, 16'h0005, 16'h0005);
    cycle();
    check_eq("t3_sub_data", 32'(rsp_data), 32'h0000);
    check_eq("t3_sub_z", 32'(flags[0]), 32'd1);
    set_r0(3'd0, 16'h7FFF, 16'h0001);
    cycle();
    check_eq("t3_add_sat", 32'(rsp_data), 32'h7FFF);
    check_eq("t3_add_flags", 32'(flags), 32'(seen_aflags));
    check_eq("t3_add_v", 32'(flags[2]), 32'd1);

    // Ops that must not disturb flags.
    set_r0(3'd1, 16'h0005, 16'h0005);
    cycle();
    check_eq("t4_flags_init", 32'(flags), 32'h1);
    set_r0(3'd7, 16'h7777, 16'h1111);
    cycle();
    check_eq("t4_paddsb", 32'(rsp_data), 32'h7777);
    check_eq("t4_paddsb_flags", 32'(flags), 32'h1);
    set_r0(3'd3, 16'h1234, 16'h5678);
    cycle();
    check_eq("t4_red", 32'(rsp_data), 32'(16'h0114));
    check_eq("t4_red_flags", 32'(flags), 32'h1);
    set_r1(3'd0, 16'h0001, 16'h0001);
    cycle();
    check_eq("t4_r1_add", 32'(rsp_data), 32'h0002);
    check_eq("t4_r1_flags", 32'(flags), 32'h1);

    // r1-only stream then an idle cycle.
    for (int k = 0; k < 3; k++) begin
      rand_r1();
      cycle();
      check_eq($sformatf("t5_rdy1_%0d", k), 32'(seen_rdy1), 32'd1);
      check_eq($sformatf("t5_rsp_valid_%0d", k), 32'(rsp_valid), 32'd1);
      check_eq($sformatf("t5_rsp_id_%0d", k), 32'(rsp_id), 32'd1);
    end
    cycle();
    check_eq("t5_idle_op", 32'(seen_op), 32'd0);
    check_eq("t5_idle_in1", 32'(seen_in1), 32'd0);
    check_eq("t5_idle_in2", 32'(seen_in2), 32'd0);
    check_eq("t5_idle_rsp_valid", 32'(rsp_valid), 32'd0);

`ifdef ALU_ARB_LOCK_EN
    r0_lock = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (!r0_valid) rand_r0();
      if (!r1_valid) rand_r1();
      cycle();
      check_eq($sformatf("t6_r1_gnt_%0d", k), 32'(seen_rdy1), 32'(k == 4));
    end
    r0_lock = 1'b0;
`endif

    random_traffic(200);

    // Asynchronous reset in the middle of traffic.
    if (!r0_valid) rand_r0();
    if (!r1_valid) rand_r1();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("t1_flags", 32'(flags), 32'd0);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'd0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("t1_hold_rdy0", 32'(r0_ready), 32'd0);
      check_eq("t1_hold_rdy1", 32'(r1_ready), 32'd0);
      check_eq("t1_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle();
    check_eq("t1_first_conflict_r0", 32'(seen_rdy0), 32'd1);

    random_traffic(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
